// File: rtl/alu_issuer.sv
// rtl/alu_issuer.sv - command issuer and in-order result collector for the pipelined alu
module alu_issuer #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             cmd_ready,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_in_valid,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_out_valid,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  input  logic             res_ready,
  output logic             err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [OW-1:0] OCC_MAX  = OW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [CW-1:0]    inflight;
  logic [CW-1:0]    count;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [OW-1:0]    occupancy;

  logic accept;
  logic pop;
  logic ret_ok;
  logic push;
  logic err_set;

  // Credit check: every slot is either filled or promised to an inflight op
  always_comb begin
    occupancy = {1'b0, count} + {1'b0, inflight};
    cmd_ready = !rst && (occupancy < OCC_MAX);
    res_valid = (count != '0);
    res_data  = mem[rd_ptr];
    accept    = cmd_valid && cmd_ready;
    pop       = res_valid && res_ready;
    // A return with nothing outstanding is bogus and never counted or stored
    ret_ok    = alu_out_valid && (inflight != '0);
    // A full FIFO only takes the return if the head leaves on the same edge
    push      = ret_ok && ((count != FULL_CNT) || pop);
    err_set   = alu_out_valid && ((inflight == '0) || ((count == FULL_CNT) && !pop));
  end

  // Issue register: load on accept, otherwise drop valid and op but keep operands
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_in_valid <= 1'b0;
      alu_op       <= 2'd0;
      alu_a        <= '0;
      alu_b        <= '0;
    end else if (accept) begin
      alu_in_valid <= 1'b1;
      alu_op       <= cmd_op;
      alu_a        <= cmd_a;
      alu_b        <= cmd_b;
    end else begin
      alu_in_valid <= 1'b0;
      alu_op       <= 2'd0;
    end
  end

  // Inflight counter: ops issued whose result has not yet come back from the alu
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({accept, ret_ok})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Result FIFO storage and write pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= alu_out;
      wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
    end
  end

  // Result FIFO read pointer and occupancy count
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky protocol error, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_issuer.sv
// tb/tb_alu_issuer.sv - directed self-checking bench for alu_issuer with behavioural alu models
module tb_alu_issuer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // DEPTH = 8 instance
  logic       c8_valid, c8_ready, a8_iv, a8_ov, r8_valid, r8_ready, err8, inj8;
  logic [1:0] c8_op, a8_op;
  logic [5:0] c8_a, c8_b, a8_a, a8_b, a8_out, r8_data;
  logic       m8_s1v, m8_ov;
  logic [1:0] m8_s1op;
  logic [5:0] m8_s1a, m8_s1b, m8_out;

  // DEPTH = 4 instance
  logic       c4_valid, c4_ready, a4_iv, r4_valid, r4_ready, err4;
  logic [1:0] c4_op, a4_op;
  logic [5:0] c4_a, c4_b, a4_a, a4_b, r4_data;
  logic       m4_s1v, m4_ov;
  logic [1:0] m4_s1op;
  logic [5:0] m4_s1a, m4_s1b, m4_out;

  assign a8_ov  = m8_ov | inj8;
  assign a8_out = inj8 ? 6'd33 : m8_out;

  alu_issuer #(.WIDTH(6), .DEPTH(8)) u8 (
    .clk(clk), .rst(rst),
    .cmd_valid(c8_valid), .cmd_op(c8_op), .cmd_a(c8_a), .cmd_b(c8_b), .cmd_ready(c8_ready),
    .alu_op(a8_op), .alu_a(a8_a), .alu_b(a8_b), .alu_in_valid(a8_iv),
    .alu_out(a8_out), .alu_out_valid(a8_ov),
    .res_valid(r8_valid), .res_data(r8_data), .res_ready(r8_ready), .err(err8)
  );

  alu_issuer #(.WIDTH(6), .DEPTH(4)) u4 (
    .clk(clk), .rst(rst),
    .cmd_valid(c4_valid), .cmd_op(c4_op), .cmd_a(c4_a), .cmd_b(c4_b), .cmd_ready(c4_ready),
    .alu_op(a4_op), .alu_a(a4_a), .alu_b(a4_b), .alu_in_valid(a4_iv),
    .alu_out(m4_out), .alu_out_valid(m4_ov),
    .res_valid(r4_valid), .res_data(r4_data), .res_ready(r4_ready), .err(err4)
  );

  function automatic logic [5:0] alu_f(input logic [1:0] op, input logic [5:0] a, input logic [5:0] b);
    case (op)
      2'd1:    return a + b;
      2'd2:    return a - b;
      default: return 6'd0;
    endcase
  endfunction

  // Two-stage alu model: samples in_valid at E1, drives out_valid after E2
  always @(posedge clk) begin
    if (rst) begin
      m8_s1v <= 1'b0; m8_ov <= 1'b0; m8_out <= 6'd0;
      m4_s1v <= 1'b0; m4_ov <= 1'b0; m4_out <= 6'd0;
      m8_s1op <= 2'd0; m8_s1a <= 6'd0; m8_s1b <= 6'd0;
      m4_s1op <= 2'd0; m4_s1a <= 6'd0; m4_s1b <= 6'd0;
    end else begin
      m8_s1v <= a8_iv; m8_s1op <= a8_op; m8_s1a <= a8_a; m8_s1b <= a8_b;
      m8_ov  <= m8_s1v; m8_out <= m8_s1v ? alu_f(m8_s1op, m8_s1a, m8_s1b) : 6'd0;
      m4_s1v <= a4_iv; m4_s1op <= a4_op; m4_s1a <= a4_a; m4_s1b <= a4_b;
      m4_ov  <= m4_s1v; m4_out <= m4_s1v ? alu_f(m4_s1op, m4_s1a, m4_s1b) : 6'd0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic single_op(input logic [1:0] op, input logic [5:0] a, input logic [5:0] b,
                           input logic [5:0] exp);
    @(posedge clk); #1;
    c8_valid = 1'b1; c8_op = op; c8_a = a; c8_b = b;
    @(posedge clk); #1;
    c8_valid = 1'b0;
    @(negedge clk);
    chk("single_issue", a8_iv, 1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("single_early", r8_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("single_valid", r8_valid, 1);
    chk("single_data", r8_data, exp);
    @(posedge clk); #1;
    r8_ready = 1'b1;
    @(posedge clk); #1;
    r8_ready = 1'b0;
    @(negedge clk);
    chk("single_popped", r8_valid, 0);
  endtask

  logic acc;
  logic spurious;
  int   sent, got, gaps, n;

  initial begin
    c8_valid = 1'b1; c8_op = 2'd1; c8_a = 6'd1; c8_b = 6'd1; r8_ready = 1'b0; inj8 = 1'b0;
    c4_valid = 1'b1; c4_op = 2'd1; c4_a = 6'd1; c4_b = 6'd1; r4_ready = 1'b0;

    // Reset held with commands offered
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_ready8", c8_ready, 0);
      chk("rst_issue8", a8_iv, 0);
      chk("rst_ready4", c4_ready, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; c8_valid = 1'b0; c4_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready8", c8_ready, 1);
    chk("post_rst_valid8", r8_valid, 0);
    chk("post_rst_err8", err8, 0);
    chk("post_rst_data8", r8_data, 0);
    chk("post_rst_ready4", c4_ready, 1);

    // Single ops with hand-computed results
    single_op(2'd1, 6'd5, 6'd7, 6'd12);
    single_op(2'd2, 6'd3, 6'd5, 6'd62);
    single_op(2'd1, 6'd63, 6'd1, 6'd0);
    single_op(2'd0, 6'd9, 6'd4, 6'd0);

    // Streaming: 20 back-to-back adds i + i
    r8_ready = 1'b1; sent = 0; got = 0; gaps = 0;
    @(posedge clk); #1;
    c8_valid = 1'b1; c8_op = 2'd1; c8_a = 6'd0; c8_b = 6'd0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (c8_valid) chk("stream_ready", c8_ready, 1);
      acc = c8_valid && c8_ready;
      if (r8_valid) begin
        chk("stream_data", r8_data, (2 * got) & 63);
        got++;
      end else if (got > 0 && got < 20) begin
        gaps++;
      end
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent == 20) c8_valid = 1'b0;
        else begin c8_a = 6'(sent); c8_b = 6'(sent); end
      end
    end
    chk("stream_sent", sent, 20);
    chk("stream_count", got, 20);
    chk("stream_gaps", gaps, 0);

    // Backpressure on DEPTH = 4: exactly four accepts, then drain and wrap
    n = 0; c4_op = 2'd1; c4_a = 6'd0; c4_b = 6'd0;
    @(posedge clk); #1;
    c4_valid = 1'b1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      acc = c4_valid && c4_ready;
      @(posedge clk); #1;
      if (acc) begin n++; c4_a = 6'(n); end
    end
    chk("bp_accepts", n, 4);
    @(negedge clk);
    chk("bp_ready", c4_ready, 0);
    chk("bp_valid", r4_valid, 1);
    chk("bp_head", r4_data, 0);
    chk("bp_err_full", err4, 0);
    @(posedge clk); #1;
    r4_ready = 1'b1; got = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      acc = c4_valid && c4_ready;
      if (r4_valid) begin
        chk("bp_data", r4_data, got);
        got++;
      end
      if (got == 14) break;
      @(posedge clk); #1;
      if (acc) begin
        n++;
        if (n == 14) c4_valid = 1'b0;
        else c4_a = 6'(n);
      end
    end
    chk("bp_total", got, 14);
    chk("bp_err", err4, 0);

    // Error injection: return with nothing outstanding
    repeat (3) @(posedge clk);
    #1 inj8 = 1'b1;
    @(posedge clk); #1;
    inj8 = 1'b0;
    @(negedge clk);
    chk("inj_err", err8, 1);
    chk("inj_dropped", r8_valid, 0);
    repeat (3) @(negedge clk);
    chk("inj_sticky", err8, 1);

    // Reset clears err, then reset in the middle of a stream
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("err_cleared", err8, 0);
    r8_ready = 1'b0; n = 0; c8_op = 2'd1; c8_a = 6'd1; c8_b = 6'd0;
    @(posedge clk); #1;
    c8_valid = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      acc = c8_valid && c8_ready;
      @(posedge clk); #1;
      if (acc) begin
        n++;
        if (n == 5) begin c8_valid = 1'b0; rst = 1'b1; break; end
        else c8_a = 6'(n + 1);
      end
    end
    chk("mid_accepts", n, 5);
    @(negedge clk);
    chk("mid_pre_valid", r8_valid, 1);
    chk("mid_pre_head", r8_data, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_valid", r8_valid, 0);
    chk("mid_ready", c8_ready, 1);
    chk("mid_err", err8, 0);
    spurious = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (r8_valid || err8) spurious = 1'b1;
    end
    chk("mid_spurious", spurious, 0);

    // Full credit is available again: exactly DEPTH accepts with no pops
    n = 0; c8_a = 6'd40;
    @(posedge clk); #1;
    c8_valid = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      acc = c8_valid && c8_ready;
      @(posedge clk); #1;
      if (acc) begin n++; c8_a = 6'(40 + n); end
    end
    c8_valid = 1'b0;
    chk("refill_accepts", n, 8);
    @(negedge clk);
    chk("refill_head", r8_data, 40);
    chk("refill_err", err8, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
